intf_skid_buf: RTL and testbench

Two-entry registered skid buffer that produces the per-instance data stream feeding the parameterized interface bundle.
- Downstream it drives the `val`-style data field; interface monitor/display modules consume that field.
- Sits directly upstream of those consumers, one instance per generate-scope interface.
- Decouples producer and consumer with a full valid/ready handshake.
- Reports its instance ID and a running transfer count.

---
 rtl/skid_pkg.sv | 22 ++
 rtl/skid_xfer_cnt.sv | 16 +
 rtl/intf_skid_buf.sv | 79 +++++++
 tb/tb_intf_skid_buf.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// skid_pkg: shared state encoding, counter width and next-state rule for the skid buffer
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int CNT_W = 16;

    // Any encoding outside the three legal states falls back to EMPTY
    function automatic skid_state_t skid_next_state(input skid_state_t state, input logic push, input logic pop);
        case (state)
            EMPTY:   return push ? ONE : EMPTY;
            ONE:     return (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            FULL:    return pop ? ONE : FULL;
            default: return EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/skid_xfer_cnt.sv
// skid_xfer_cnt: wrapping transfer counter, bumps once per completed output transfer
module skid_xfer_cnt
    import skid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + CNT_W'(inc);
    end

endmodule

// File: rtl/intf_skid_buf.sv
// intf_skid_buf: two-entry registered skid buffer with transfer count and constant instance ID.
// Optional even-parity sideband on the head entry when SKID_PARITY_EN is defined.
module intf_skid_buf
    import skid_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ID    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [7:0]       id_o
`ifdef SKID_PARITY_EN
    ,
    output logic             out_par
`endif
);

`ifdef SKID_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    skid_state_t state, state_nxt;
    logic [EW-1:0] head, tail, din;
    logic push, pop, load_head, head_from_tail, load_tail;

`ifdef SKID_PARITY_EN
    assign din     = {^in_data, in_data};
    assign out_par = head[WIDTH];
`else
    assign din = in_data;
`endif

    assign out_data = head[WIDTH-1:0];
    assign id_o     = 8'(ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Handshake flags decode the state register only, so in_ready never sees out_ready
    always_comb begin
        out_valid      = (state == ONE) || (state == FULL);
        in_ready       = (state == EMPTY) || (state == ONE);
        push           = in_valid && in_ready;
        pop            = out_valid && out_ready;
        state_nxt      = skid_next_state(state, push, pop);
        load_head      = ((state == EMPTY) && push) || ((state == ONE) && push && pop) || ((state == FULL) && pop);
        head_from_tail = (state == FULL);
        load_tail      = (state == ONE) && push && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) head <= head_from_tail ? tail : din;
            if (load_tail) tail <= din;
        end
    end

    skid_xfer_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .cnt   (xfer_cnt)
    );

endmodule

// File: tb/tb_intf_skid_buf.sv
// tb_intf_skid_buf: vector table, directed corner sequences and random traffic against a queue model
module tb_intf_skid_buf;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  xfer_cnt;
    logic [7:0]   id_o;
`ifdef SKID_PARITY_EN
    logic         out_par;
`endif

    int checks = 0;
    int failures = 0;

    // Reference: a bounded FIFO of capacity two plus a modulo-2^16 pop counter
    logic [W-1:0] q[$];
    logic [15:0]  mcnt = '0;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
        logic [15:0]  ec;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    intf_skid_buf #(.WIDTH(W), .ID(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt),
        .id_o      (id_o)
`ifdef SKID_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic cmp_model(input string n);
        chk({n, " out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({n, " in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        chk({n, " xfer_cnt"}, 64'(xfer_cnt), 64'(mcnt));
        if (q.size() > 0) begin
            chk({n, " out_data"}, 64'(out_data), 64'(q[0]));
`ifdef SKID_PARITY_EN
            chk({n, " out_par"}, 64'(out_par), 64'(^q[0]));
`endif
        end
    endtask

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input string n);
        logic push, pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        push = iv && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            mcnt++;
        end
        if (push) q.push_back(d);
        #1 cmp_model(n);
    endtask

    initial begin
        logic [15:0] c0;
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 16'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 16'd1};
        tbl[2] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 16'd1};
        tbl[3] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 16'd1};
        tbl[4] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 16'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 16'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 16'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("id_o", 64'(id_o), 64'h02);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, "tbl");
            chk($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d in_ready", i), 64'(in_ready), 64'(tbl[i].er));
            chk($sformatf("tbl%0d xfer_cnt", i), 64'(xfer_cnt), 64'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("tbl%0d out_data", i), 64'(out_data), 64'(tbl[i].ed));
        end

        c0 = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, W'(i), 1'b1, "stream");
            chk("stream data", 64'(out_data), 64'(i));
            chk("stream in_ready", 64'(in_ready), 64'd1);
        end
        cyc(1'b0, '0, 1'b1, "stream drain");
        chk("stream count", 64'(xfer_cnt - c0), 64'd10);

        cyc(1'b1, 8'h44, 1'b0, "fill44");
        cyc(1'b1, 8'h55, 1'b0, "fill55");
        chk("full in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        chk("async rst out_data", 64'(out_data), 64'd0);
        chk("async rst xfer_cnt", 64'(xfer_cnt), 64'd0);
        q.delete();
        mcnt = '0;
        @(negedge clk) rst_n = 1'b1;
        cyc(1'b0, '0, 1'b1, "post rst");
        cyc(1'b0, '0, 1'b1, "post rst2");

        force dut.u_cnt.cnt = 16'hFFFE;
        #1 release dut.u_cnt.cnt;
        mcnt = 16'hFFFE;
        chk("preset cnt", 64'(xfer_cnt), 64'hFFFE);
        cyc(1'b1, 8'h01, 1'b1, "wrap0");
        cyc(1'b1, 8'h02, 1'b1, "wrap1");
        chk("wrap FFFF", 64'(xfer_cnt), 64'hFFFF);
        cyc(1'b1, 8'h03, 1'b1, "wrap2");
        chk("wrap 0000", 64'(xfer_cnt), 64'h0000);
        cyc(1'b0, '0, 1'b1, "wrap3");
        chk("wrap 0001", 64'(xfer_cnt), 64'h0001);

`ifdef SKID_PARITY_EN
        cyc(1'b1, 8'h07, 1'b0, "par07");
        chk("par 07", 64'(out_par), 64'd1);
        cyc(1'b1, 8'h03, 1'b0, "par03 push");
        cyc(1'b0, '0, 1'b1, "par03 head");
        chk("par 03", 64'(out_par), 64'd0);
        cyc(1'b0, '0, 1'b1, "par drain");
`endif

        repeat (500) begin
            cyc(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0), "rand");
        end
        repeat (200) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) == 0), "rand slow");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
